ctrl_pipe_chain: RTL and testbench



---
 rtl/ctrl_pipe_chain.sv | 114 +++++++++++
 tb/tb_ctrl_pipe_chain.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
// ctrl_pipe_chain: per-stage control-bundle registers with stall/flush/bubbles,
// stall echo and stall-ordering violation pulse. Optional counters: CTRL_PIPE_STALLCNT_EN.
// Revision: 1.0
// ============================================================================
module ctrl_pipe_chain #(
  parameter int WIDTH  = 17,
  parameter int STAGES = 3,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_ctrl,
  input  logic                      in_valid,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES*WIDTH-1:0]   stage_ctrl,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES-1:0]         stall_q,
  output logic                      stall_viol,
  output logic [STAGES*CNT_W-1:0]   stall_cnt
);

  logic [STAGES-1:0][WIDTH-1:0] ctrl_q, ctrl_d, src_ctrl;
  logic [STAGES-1:0]            valid_q, valid_d, src_valid, up_stall;
  logic [STAGES-1:0]            viol_vec;
  logic [STAGES-1:0]            stall_echo_q;
  logic                         viol_q;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign src_ctrl[k]  = in_ctrl;
        assign src_valid[k] = in_valid;
        assign up_stall[k]  = 1'b0;
        assign viol_vec[k]  = 1'b0;
      end else begin : g_tail
        assign src_ctrl[k]  = ctrl_q[k-1];
        assign src_valid[k] = valid_q[k-1];
        assign up_stall[k]  = stall[k-1];
        // A stage stalling while a live upstream stage advances into it loses data.
        assign viol_vec[k]  = stall[k] & ~stall[k-1] & ~flush[k-1] & valid_q[k-1];
      end
    end
  endgenerate

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush[i]) begin
        ctrl_d[i]  = '0;
        valid_d[i] = 1'b0;
      end else if (stall[i]) begin
        ctrl_d[i]  = ctrl_q[i];
        valid_d[i] = valid_q[i];
      end else if (up_stall[i]) begin
        ctrl_d[i]  = '0;
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = src_valid[i];
        ctrl_d[i]  = src_valid[i] ? src_ctrl[i] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      valid_q      <= '0;
      stall_echo_q <= '0;
      viol_q       <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      valid_q      <= valid_d;
      stall_echo_q <= stall & ~flush;
      viol_q       <= |viol_vec;
    end
  end

  assign stage_ctrl  = ctrl_q;
  assign stage_valid = valid_q;
  assign stall_q     = stall_echo_q;
  assign stall_viol  = viol_q;

`ifdef CTRL_PIPE_STALLCNT_EN
  logic [STAGES-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (!flush[i] && stall[i] && valid_q[i]) begin
        cnt_d[i] = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_chain.sv
`default_nettype none
// Testbench for ctrl_pipe_chain: directed plan followed by random traffic,
// every edge compared against a rule-level reference model.
module tb_ctrl_pipe_chain;
  localparam int WIDTH  = 17;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WIDTH-1:0]        in_ctrl;
  logic                    in_valid;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic [STAGES*WIDTH-1:0] stage_ctrl;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES-1:0]       stall_q;
  logic                    stall_viol;
  logic [STAGES*CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  ctrl_pipe_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid),
    .stall(stall), .flush(flush), .stage_ctrl(stage_ctrl),
    .stage_valid(stage_valid), .stall_q(stall_q), .stall_viol(stall_viol),
    .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_ctrl [STAGES];
  logic             m_valid[STAGES];
  logic             m_stq  [STAGES];
  logic             m_viol;
  int               m_cnt  [STAGES];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] sc(input int k);
    return stage_ctrl[k*WIDTH +: WIDTH];
  endfunction

  function automatic int sn(input int k);
    return int'(stall_cnt[k*CNT_W +: CNT_W]);
  endfunction

  // Advance one clock: model computes the next state from the current inputs,
  // then the DUT is compared against it just after the edge.
  task automatic step();
    logic [WIDTH-1:0] nc[STAGES];
    logic             nv[STAGES];
    logic             ns[STAGES];
    int               nk[STAGES];
    logic             viol;
    logic [STAGES*WIDTH-1:0] e_ctrl;
    logic [STAGES-1:0]       e_valid, e_stq;
    logic [STAGES*CNT_W-1:0] e_cnt;
    viol = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      logic [WIDTH-1:0] s_c;
      logic             s_v;
      logic             up;
      s_c = (k == 0) ? in_ctrl  : m_ctrl[(k > 0) ? k-1 : 0];
      s_v = (k == 0) ? in_valid : m_valid[(k > 0) ? k-1 : 0];
      up  = (k > 0) && stall[(k > 0) ? k-1 : 0];
      if (rst) begin
        nc[k] = '0; nv[k] = 1'b0; ns[k] = 1'b0; nk[k] = 0;
      end else begin
        if (flush[k])      begin nc[k] = '0; nv[k] = 1'b0; end
        else if (stall[k]) begin nc[k] = m_ctrl[k]; nv[k] = m_valid[k]; end
        else if (up)       begin nc[k] = '0; nv[k] = 1'b0; end
        else               begin nv[k] = s_v; nc[k] = s_v ? s_c : '0; end
        ns[k] = stall[k] && !flush[k];
        nk[k] = (stall[k] && !flush[k] && m_valid[k]) ?
                ((m_cnt[k] + 1 > CMAX) ? CMAX : m_cnt[k] + 1) : 0;
        if (k > 0 && stall[k] && !up && !flush[k-1] && m_valid[k-1]) viol = 1'b1;
      end
    end
    @(posedge clk);
    for (int k = 0; k < STAGES; k++) begin
      m_ctrl[k] = nc[k]; m_valid[k] = nv[k]; m_stq[k] = ns[k]; m_cnt[k] = nk[k];
    end
    m_viol = viol;
    #1;
    for (int k = 0; k < STAGES; k++) begin
      e_ctrl[k*WIDTH +: WIDTH] = m_ctrl[k];
      e_valid[k] = m_valid[k];
      e_stq[k]   = m_stq[k];
`ifdef CTRL_PIPE_STALLCNT_EN
      e_cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
`else
      e_cnt[k*CNT_W +: CNT_W] = '0;
`endif
    end
    check("stage_ctrl",  64'(stage_ctrl),  64'(e_ctrl));
    check("stage_valid", 64'(stage_valid), 64'(e_valid));
    check("stall_q",     64'(stall_q),     64'(e_stq));
    check("stall_viol",  64'(stall_viol),  64'(m_viol));
    check("stall_cnt",   64'(stall_cnt),   64'(e_cnt));
  endtask

  initial begin
    for (int k = 0; k < STAGES; k++) m_cnt[k] = 0;
    rst = 1'b1; in_ctrl = '0; in_valid = 1'b0; stall = '0; flush = '0;
    step();
    check("reset_valid", 64'(stage_valid), 64'(0));
    check("reset_ctrl",  64'(stage_ctrl),  64'(0));
    rst = 1'b0;

    // Free-flow latency
    in_valid = 1'b1; in_ctrl = 17'h00001; step();
    in_ctrl = 17'h00002; step();
    in_ctrl = 17'h00003; step();
    check("tp1_s2_first", 64'(sc(2)), 64'(17'h00001));
    check("tp1_v2_first", 64'(stage_valid[2]), 64'(1));
    in_valid = 1'b0; in_ctrl = 17'h1FFFF; step();
    check("tp1_s2_second", 64'(sc(2)), 64'(17'h00002));
    step();
    check("tp1_s2_third", 64'(sc(2)), 64'(17'h00003));
    check("tp1_s0_forced0", 64'(sc(0)), 64'(0));

    // Stall at stage 0 inserts bubbles into stage 1
    in_valid = 1'b1; in_ctrl = 17'h00005; step();
    stall = 3'b001; in_ctrl = 17'h00006;
    for (int i = 0; i < 2; i++) begin
      step();
      check("tp2_s0_hold",  64'(sc(0)), 64'(17'h00005));
      check("tp2_s1_ctrl",  64'(sc(1)), 64'(0));
      check("tp2_s1_valid", 64'(stage_valid[1]), 64'(0));
      check("tp2_stallq0",  64'(stall_q[0]), 64'(1));
    end
    stall = '0; step();

    // Flush beats stall
    in_ctrl = 17'h0000A; step();
    in_ctrl = 17'h0000B; step();
    check("tp3_s1_pre", 64'(sc(1)), 64'(17'h0000A));
    stall = 3'b011; flush = 3'b010; in_ctrl = 17'h0000C; step();
    check("tp3_s1_flushed", 64'(sc(1)), 64'(0));
    check("tp3_v1_flushed", 64'(stage_valid[1]), 64'(0));
    check("tp3_s0_held",    64'(sc(0)), 64'(17'h0000B));
    check("tp3_stallq1",    64'(stall_q[1]), 64'(0));
    stall = '0; flush = '0; step();

    // Stall ordering violation pulses once; legal ordering stays quiet
    stall = 3'b010; step();
    check("tp4_viol_pulse", 64'(stall_viol), 64'(1));
    stall = 3'b000; step();
    check("tp4_viol_clear", 64'(stall_viol), 64'(0));
    stall = 3'b011; step();
    stall = 3'b000; step();
    check("tp4_legal_quiet", 64'(stall_viol), 64'(0));

    // Reset while the full pipe is stalled
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_ctrl = 17'(i + 'h20); step(); end
    stall = 3'b111; step();
    rst = 1'b1; step();
    check("tp5_rst_ctrl",  64'(stage_ctrl),  64'(0));
    check("tp5_rst_valid", 64'(stage_valid), 64'(0));
    check("tp5_rst_stq",   64'(stall_q),     64'(0));
    rst = 1'b0; stall = '0;
    for (int i = 0; i < 3; i++) begin in_ctrl = 17'(i + 'h30); step(); end
    check("tp5_refill", 64'(sc(2)), 64'(17'h00030));

    // Stage-0 hold duration
    in_ctrl = 17'h00077; step();
    stall = 3'b001;
    for (int i = 1; i <= 20; i++) begin
      step();
`ifdef CTRL_PIPE_STALLCNT_EN
      check("tp6_cnt", 64'(sn(0)), 64'((i > CMAX) ? CMAX : i));
`else
      check("tp6_cnt_off", 64'(sn(0)), 64'(0));
`endif
    end
    stall = '0; step();
    check("tp6_cnt_release", 64'(sn(0)), 64'(0));

    // Random traffic, mostly legal stall ordering with occasional violations
    for (int n = 0; n < 400; n++) begin
      int depth;
      in_ctrl  = WIDTH'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      depth    = $urandom_range(0, STAGES + 2);
      if ($urandom_range(0, 7) == 0) stall = STAGES'($urandom);
      else if (depth >= STAGES) stall = '0;
      else stall = STAGES'((1 << (depth + 1)) - 1);
      for (int k = 0; k < STAGES; k++) flush[k] = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
